// File: rtl/uart_cal_ctrl.sv
// uart_cal_ctrl: parses A5/OP/A/B request frames from the UART, runs the 8-bit calculator
// and paces a 5A/STATUS/RES response onto the TX strobe. Optional macro: CAL_CHKSUM_EN.
module uart_cal_ctrl #(
  parameter int unsigned TX_BYTE_CYCLES = 4400,
  parameter int unsigned RX_TIMEOUT     = 100000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       frame_err
);
  localparam int unsigned TO_W = $clog2(RX_TIMEOUT);
  localparam int unsigned SL_W = $clog2(TX_BYTE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);
  localparam logic [SL_W-1:0] SL_LAST = SL_W'(TX_BYTE_CYCLES - 1);
`ifdef CAL_CHKSUM_EN
  localparam logic [2:0] N_BYTES = 3'd5;
`else
  localparam logic [2:0] N_BYTES = 3'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_OP,
    S_GET_A,
    S_GET_B,
`ifdef CAL_CHKSUM_EN
    S_GET_CS,
`endif
    S_EXEC,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d, a_q, a_d, b_q, b_d;
`ifdef CAL_CHKSUM_EN
  logic [7:0]        cs_q, cs_d;
`endif
  logic [15:0]       res_q, res_d;
  logic [7:0]        status_q, status_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [SL_W-1:0]   slot_q, slot_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              in_frame;
  logic [15:0]       a16, b16;
  logic [7:0]        resp_byte;

  // idx_q counts bytes already launched, so it selects the next byte to send
  always_comb begin
    resp_byte = 8'h5A;
    case (idx_q)
      3'd1:    resp_byte = status_q;
      3'd2:    resp_byte = res_q[15:8];
      3'd3:    resp_byte = res_q[7:0];
`ifdef CAL_CHKSUM_EN
      3'd4:    resp_byte = status_q ^ res_q[15:8] ^ res_q[7:0];
`endif
      default: resp_byte = 8'h5A;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
`ifdef CAL_CHKSUM_EN
    cs_d        = cs_q;
`endif
    res_d       = res_q;
    status_d    = status_q;
    to_cnt_d    = to_cnt_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    a16         = {8'h00, a_q};
    b16         = {8'h00, b_q};

    unique case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (rx_valid && rx_data == 8'hA5) state_d = S_GET_OP;
      end
      S_GET_OP: if (rx_valid) begin op_d = rx_data; state_d = S_GET_A; end
      S_GET_A:  if (rx_valid) begin a_d  = rx_data; state_d = S_GET_B; end
`ifdef CAL_CHKSUM_EN
      S_GET_B:  if (rx_valid) begin b_d  = rx_data; state_d = S_GET_CS; end
      S_GET_CS: if (rx_valid) begin cs_d = rx_data; state_d = S_EXEC; end
`else
      S_GET_B:  if (rx_valid) begin b_d  = rx_data; state_d = S_EXEC; end
`endif
      S_EXEC: begin
        status_d = 8'h00;
        unique case (op_q)
          8'h00:   res_d = a16 + b16;
          8'h01:   res_d = a16 - b16;
          8'h02:   res_d = a16 * b16;
          8'h03:   res_d = {8'h00, a_q & b_q};
          default: begin res_d = '0; status_d = 8'h01; end
        endcase
`ifdef CAL_CHKSUM_EN
        if (cs_q != (op_q ^ a_q ^ b_q)) begin
          res_d    = '0;
          status_d = 8'h02;
        end
`endif
        tx_data_d  = 8'h5A;
        tx_valid_d = 1'b1;
        idx_d      = 3'd1;
        slot_d     = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (slot_q == SL_LAST) begin
          slot_d = '0;
          if (idx_q == N_BYTES) begin
            state_d = S_IDLE;
          end else begin
            tx_data_d  = resp_byte;
            tx_valid_d = 1'b1;
            idx_d      = idx_q + 3'd1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // an arriving byte always beats a simultaneous expiry
    if (in_frame) begin
      if (rx_valid) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

`ifdef CAL_CHKSUM_EN
  assign in_frame = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                    (state_q == S_GET_B)  || (state_q == S_GET_CS);
`else
  assign in_frame = (state_q == S_GET_OP) || (state_q == S_GET_A) || (state_q == S_GET_B);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
`ifdef CAL_CHKSUM_EN
      cs_q        <= '0;
`endif
      res_q       <= '0;
      status_q    <= '0;
      to_cnt_q    <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef CAL_CHKSUM_EN
      cs_q        <= cs_d;
`endif
      res_q       <= res_d;
      status_q    <= status_d;
      to_cnt_q    <= to_cnt_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_cal_ctrl.sv
// Directed bench for uart_cal_ctrl: expected response bytes are queued when a request is sent
// and checked (value and pacing) as tx_valid strobes appear. Honours CAL_CHKSUM_EN.
module tb_uart_cal_ctrl;
  localparam int unsigned TXC = 20;
  localparam int unsigned RXT = 50;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_err;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_rx_cyc = 0;
  int unsigned b_cyc = 0;
  int unsigned last_tx_cyc = 0;
  exp_t        exp_q[$];
  exp_t        e;

  uart_cal_ctrl #(.TX_BYTE_CYCLES(TXC), .RX_TIMEOUT(RXT)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d want completion", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every launched byte must match the queue head, with correct pacing.
  always @(negedge clk) begin
    if (tx_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++; $error("FAIL tx_unexpected got=%02h want=no_pulse", tx_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (tx_data === e.data) else begin
          errors++; $error("FAIL tx_data got=%02h want=%02h", tx_data, e.data);
        end
        checks++;
        if (e.first) begin
          assert (cyc - b_cyc === 32'd2) else begin
            errors++; $error("FAIL tx_latency got=%0d want=2", cyc - b_cyc);
          end
        end else begin
          assert (cyc - last_tx_cyc === TXC) else begin
            errors++; $error("FAIL tx_spacing got=%0d want=%0d", cyc - last_tx_cyc, TXC);
          end
        end
      end
      last_tx_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1; last_rx_cyc = cyc;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic push_resp(input logic [7:0] st, input logic [15:0] res);
    exp_q.push_back('{data: 8'h5A, first: 1'b1});
    exp_q.push_back('{data: st, first: 1'b0});
    exp_q.push_back('{data: res[15:8], first: 1'b0});
    exp_q.push_back('{data: res[7:0], first: 1'b0});
`ifdef CAL_CHKSUM_EN
    exp_q.push_back('{data: st ^ res[15:8] ^ res[7:0], first: 1'b0});
`endif
  endtask

  // cs_flip corrupts the checksum byte (only meaningful with CAL_CHKSUM_EN)
  task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] cs_flip, input logic [7:0] st, input logic [15:0] res,
                       input string tag);
    push_resp(st, res);
    send_byte(8'hA5);
    checks++;
    assert (busy === 1'b1) else begin
      errors++; $error("FAIL %s_busy_rise got=%b want=1", tag, busy);
    end
    send_byte(op);
    send_byte(a);
    send_byte(b);
`ifdef CAL_CHKSUM_EN
    send_byte(op ^ a ^ b ^ cs_flip);
`else
    if (cs_flip != 8'h00) $display("note: %s checksum corruption unused in this build", tag);
`endif
    b_cyc = last_rx_cyc;
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick(); n++;
    end
    checks++;
    assert (exp_q.size() == 0 && busy === 1'b0) else begin
      errors++;
      $error("FAIL %s_done pending=%0d busy=%b want pending=0 busy=0", tag, exp_q.size(), busy);
    end
  endtask

  initial begin
    int unsigned pulses;
    int unsigned at;
    int unsigned seen;
    int unsigned n;
    logic        busy_pre;

    // reset values
    tick(); tick();
    checks++; assert (tx_data === 8'h00) else begin errors++; $error("FAIL rst_tx_data got=%02h want=00", tx_data); end
    checks++; assert (tx_valid === 1'b0) else begin errors++; $error("FAIL rst_tx_valid got=%b want=0", tx_valid); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy got=%b want=0", busy); end
    checks++; assert (frame_err === 1'b0) else begin errors++; $error("FAIL rst_frame_err got=%b want=0", frame_err); end
    n_rst = 1'b1;
    tick(); tick();

    // ADD
    frame(8'h00, 8'h7F, 8'h81, 8'h00, 8'h00, 16'h0100, "add");
    wait_idle(300, "add");

    // SUB wrap, with a full request injected while the response is being sent
    frame(8'h01, 8'h03, 8'h05, 8'h00, 8'h00, 16'hFFFE, "sub");
    repeat (3) tick();
    send_byte(8'hA5); repeat (4) tick();
    send_byte(8'h00); repeat (4) tick();
    send_byte(8'h01); repeat (4) tick();
    send_byte(8'h02); repeat (4) tick();
    send_byte(8'h03);
    wait_idle(300, "sub");
    repeat (10) tick();
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL inject_ignored busy=%b want=0", busy); end

    // MUL
    frame(8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00, 16'hFE01, "mul");
    wait_idle(300, "mul");

    // noise before header, then a bad opcode
    send_byte(8'h11); send_byte(8'h22); tick();
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL noise_busy got=%b want=0", busy); end
    frame(8'h07, 8'h10, 8'h20, 8'h00, 8'h01, 16'h0000, "badop");
    wait_idle(300, "badop");

    // timeout after header + opcode
    send_byte(8'hA5);
    send_byte(8'h00);
    pulses = 0; at = 0; busy_pre = 1'b0;
    for (int unsigned i = 1; i <= 60; i++) begin
      tick();
      if (i == 49) busy_pre = busy;
      if (frame_err) begin pulses++; at = i; end
    end
    checks++; assert (pulses == 1) else begin errors++; $error("FAIL to_pulses got=%0d want=1", pulses); end
    checks++; assert (at == RXT) else begin errors++; $error("FAIL to_cycle got=%0d want=%0d", at, RXT); end
    checks++; assert (busy_pre === 1'b1) else begin errors++; $error("FAIL to_busy_pre got=%b want=1", busy_pre); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL to_busy_post got=%b want=0", busy); end

    // recovery after timeout
    frame(8'h03, 8'hF0, 8'h3C, 8'h00, 8'h00, 16'h0030, "and");
    wait_idle(300, "and");

`ifdef CAL_CHKSUM_EN
    frame(8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 16'h0003, "cs_ok");
    wait_idle(300, "cs_ok");
    frame(8'h00, 8'h01, 8'h02, 8'h03, 8'h02, 16'h0000, "cs_bad");
    wait_idle(300, "cs_bad");
`endif

    // reset asserted while the 2nd response byte is on the strobe
    exp_q.push_back('{data: 8'h5A, first: 1'b1});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h7F); send_byte(8'h81);
`ifdef CAL_CHKSUM_EN
    send_byte(8'hFE);
`endif
    b_cyc = last_rx_cyc;
    seen = 0; n = 0;
    while (seen < 2 && n < 200) begin
      tick(); n++;
      if (tx_valid) seen++;
    end
    checks++; assert (seen == 2) else begin errors++; $error("FAIL rst_mid_seen got=%0d want=2", seen); end
    checks++; assert (tx_data === 8'h00) else begin errors++; $error("FAIL rst_mid_byte2 got=%02h want=00", tx_data); end
    #1 n_rst = 1'b0;
    #1;
    checks++; assert (tx_valid === 1'b0) else begin errors++; $error("FAIL rst_mid_tx_valid got=%b want=0", tx_valid); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL rst_mid_busy got=%b want=0", busy); end
    checks++; assert (tx_data === 8'h00) else begin errors++; $error("FAIL rst_mid_tx_data got=%02h want=00", tx_data); end
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (150) tick();
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL post_rst_busy got=%b want=0", busy); end
    checks++; assert (exp_q.size() == 0) else begin errors++; $error("FAIL post_rst_queue got=%0d want=0", exp_q.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
